mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the single RAM port between the instruction-fetch path and the data-memory path of the MIPS core. It accepts the iREN and dREN/dWEN requests that the decode unit's control signals produce and grants one requester at a time. It latches the granted address and store data, then holds the RAM request until the RAM signals completion. It sits between the pipeline/datapath and the RAM model; data requests take priority, with an optional instruction anti-starvation guard.

## Interface
- STARVE_MAX, 4: consecutive data grants tolerated while iREN is pending before instruction is forced (only with guard macro); range 1–15
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-high reset
- iREN  in  1  instruction read request, held until iwait low
- iaddr  in  32  instruction address (word_t)
- iwait  out  1  high while iREN pending and not acknowledged
- iload  out  32  instruction word, valid in iwait-low cycle
- dREN  in  1  data read request
- dWEN  in  1  data write request (wins if dREN also high)
- daddr  in  32  data address
- dstore  in  32  write data
- dwait  out  1  high while (dREN|dWEN) pending and not acknowledged
- dload  out  32  read data, valid in dwait-low cycle
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  32  RAM address (registered)
- ramstore  out  32  RAM write data (registered)
- ramload  in  32  RAM read data
- ramready  in  1  RAM completes current access this cycle

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D.
- IDLE: if dREN|dWEN → BUSY_D, latch daddr/dstore, latch op (write if dWEN); else if iREN → BUSY_I, latch iaddr; else stay. RAM strobes low in IDLE.
- BUSY_I: ramREN=1, ramWEN=0. On ramready: iwait=0, iload=ramload same cycle; next IDLE.
- BUSY_D: ramREN=~op_write, ramWEN=op_write. On ramready: dwait=0, dload=ramload (reads; don't-care on writes); next IDLE.
- iwait = iREN & ~(BUSY_I & ramready); dwait = (dREN|dWEN) & ~(BUSY_D & ramready). Both combinational.
- Requester dropping its request during BUSY: transaction still runs to ramready (RAM cannot abort); ack discarded; back to IDLE.
- ramaddr/ramstore change only at grant; stable throughout BUSY.

## Timing
- Reset (async): state IDLE, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, starve count=0. iwait/dwait follow their equations (high if request asserted), iload/dload=0.
- Grant cycle T: request sampled in IDLE. Strobes high from T+1. Earliest ack T+1 (ramready=1 in T+1).
- Latency = 1 + number of BUSY cycles until ramready; no upper bound (no timeout).
- One idle cycle is mandatory between transactions. Back-to-back requests therefore ack at best every 2 cycles.
- Simultaneous iREN and dREN in IDLE: data granted; instruction granted in the IDLE cycle after the data ack unless a new data request is present (subject to Configuration).
- ramready in IDLE is ignored.

## Configuration
- MEM_ARB_STARVE_GUARD_EN defined:
  - 4-bit counter increments on each data grant made while iREN is high.
  - Counter clears on any instruction grant, and on any grant made with iREN low.
  - When counter == STARVE_MAX and iREN is high in IDLE, the instruction is granted even if a data request is present; counter then clears.
- Undefined: strict data priority; counter absent; STARVE_MAX unused.

## Test plan
- Single fetch: iREN=1, iaddr=0x40, ramready high 2 cycles after grant, ramload=0x8C220004 → ramREN high T+1..T+2, ramaddr=0x40, iwait low only at T+2, iload=0x8C220004.
- Store: dWEN=1, daddr=0x100, dstore=0xDEADBEEF, ramready=1 always → ramWEN=1 at T+1, ramstore=0xDEADBEEF, dwait low T+1, ramREN stays 0.
- Contention: iREN=dREN=1 in IDLE, ramready=1 → data acked T+1; instruction granted T+2 and acked T+3.
- Starvation (macro on, STARVE_MAX=2): iREN held, dREN held continuously → data, data, then instruction grant; without macro, instruction never acked.
- Abort: dREN drops at T+1 while ramready=0 until T+4 → ramREN held through T+4, state IDLE at T+5, pending iREN granted T+5.
- Async reset mid-BUSY_D: RST pulsed between edges → ramREN/ramWEN fall immediately, ramaddr=0, state IDLE; request re-granted after release.

Source files
------------

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter for the MIPS core: data requests win over fetch.
// Define MEM_ARB_STARVE_GUARD_EN to force a fetch after STARVE_MAX data grants.
module mem_arbiter
`ifdef MEM_ARB_STARVE_GUARD_EN
#(
    parameter int unsigned STARVE_MAX = 4
)
`endif
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic        ramready
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D
    } state_t;

    state_t      state, state_n;
    logic        op_write, op_write_n;
    logic [31:0] ramaddr_n, ramstore_n;
    logic        dreq;
    logic        force_i;
    logic        grant_i, grant_d;
    logic        ack_i, ack_d;

    assign dreq = dREN | dWEN;

`ifdef MEM_ARB_STARVE_GUARD_EN
    logic [3:0] starve_cnt, starve_cnt_n;

    assign force_i = iREN && (starve_cnt == 4'(STARVE_MAX));

    // Only data grants that made a waiting fetch wait any longer count.
    always_comb begin
        starve_cnt_n = starve_cnt;
        if (grant_i)
            starve_cnt_n = '0;
        else if (grant_d)
            starve_cnt_n = iREN ? starve_cnt + 4'd1 : 4'd0;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            starve_cnt <= '0;
        else
            starve_cnt <= starve_cnt_n;
    end
`else
    assign force_i = 1'b0;
`endif

    always_comb begin
        state_n    = state;
        op_write_n = op_write;
        ramaddr_n  = ramaddr;
        ramstore_n = ramstore;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        unique case (state)
            IDLE: begin
                if (force_i) begin
                    grant_i = 1'b1;
                end else if (dreq) begin
                    grant_d = 1'b1;
                end else if (iREN) begin
                    grant_i = 1'b1;
                end
                if (grant_i) begin
                    state_n   = BUSY_I;
                    ramaddr_n = iaddr;
                end
                if (grant_d) begin
                    state_n    = BUSY_D;
                    ramaddr_n  = daddr;
                    ramstore_n = dstore;
                    op_write_n = dWEN;
                end
            end
            // The RAM cannot abort, so BUSY always waits for ramready.
            BUSY_I, BUSY_D: begin
                if (ramready)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            op_write <= 1'b0;
            ramaddr  <= '0;
            ramstore <= '0;
        end else begin
            state    <= state_n;
            op_write <= op_write_n;
            ramaddr  <= ramaddr_n;
            ramstore <= ramstore_n;
        end
    end

    assign ack_i = (state == BUSY_I) && ramready;
    assign ack_d = (state == BUSY_D) && ramready;

    assign ramREN = (state == BUSY_I) || ((state == BUSY_D) && !op_write);
    assign ramWEN = (state == BUSY_D) && op_write;

    assign iwait = iREN & ~ack_i;
    assign dwait = dreq & ~ack_d;
    assign iload = ack_i ? ramload : '0;
    assign dload = ack_d ? ramload : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
// Starvation expectations follow MEM_ARB_STARVE_GUARD_EN (STARVE_MAX=2).
module tb_mem_arbiter;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        iREN = 1'b0;
    logic [31:0] iaddr = '0;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN = 1'b0;
    logic        dWEN = 1'b0;
    logic [31:0] daddr = '0;
    logic [31:0] dstore = '0;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload = '0;
    logic        ramready = 1'b0;

    int checks = 0;
    int failures = 0;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
    mem_arbiter #(.STARVE_MAX(2)) dut (
`else
    localparam bit GUARD = 1'b0;
    mem_arbiter dut (
`endif
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramready(ramready)
    );

    always #5 CLK = ~CLK;

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        iREN = 1'b1; dWEN = 1'b1; ramload = 32'hFFFF_FFFF; ramready = 1'b1;
        cyc(); cyc(); #1;
        checks++; if (ramREN !== 1'b0) begin failures++; $display("FAIL rst_ramREN got=%0h exp=0", ramREN); end
        checks++; if (ramWEN !== 1'b0) begin failures++; $display("FAIL rst_ramWEN got=%0h exp=0", ramWEN); end
        checks++; if (ramaddr !== 32'h0) begin failures++; $display("FAIL rst_ramaddr got=%0h exp=0", ramaddr); end
        checks++; if (ramstore !== 32'h0) begin failures++; $display("FAIL rst_ramstore got=%0h exp=0", ramstore); end
        checks++; if (iwait !== 1'b1) begin failures++; $display("FAIL rst_iwait got=%0h exp=1", iwait); end
        checks++; if (dwait !== 1'b1) begin failures++; $display("FAIL rst_dwait got=%0h exp=1", dwait); end
        checks++; if (iload !== 32'h0) begin failures++; $display("FAIL rst_iload got=%0h exp=0", iload); end
        checks++; if (dload !== 32'h0) begin failures++; $display("FAIL rst_dload got=%0h exp=0", dload); end
        iREN = 1'b0; dWEN = 1'b0; ramready = 1'b0; ramload = '0;
        #1 RST = 1'b0;
        cyc();
    endtask

    task automatic test_fetch();
        iREN = 1'b1; iaddr = 32'h40; #1;
        checks++; if (iwait !== 1'b1) begin failures++; $display("FAIL fetch_iwait_T got=%0h exp=1", iwait); end
        cyc(); #1;
        checks++; if (ramREN !== 1'b1) begin failures++; $display("FAIL fetch_ren_T1 got=%0h exp=1", ramREN); end
        checks++; if (ramaddr !== 32'h40) begin failures++; $display("FAIL fetch_addr got=%0h exp=40", ramaddr); end
        checks++; if (iwait !== 1'b1) begin failures++; $display("FAIL fetch_iwait_T1 got=%0h exp=1", iwait); end
        cyc();
        ramready = 1'b1; ramload = 32'h8C22_0004; #1;
        checks++; if (ramREN !== 1'b1) begin failures++; $display("FAIL fetch_ren_T2 got=%0h exp=1", ramREN); end
        checks++; if (iwait !== 1'b0) begin failures++; $display("FAIL fetch_iwait_T2 got=%0h exp=0", iwait); end
        checks++; if (iload !== 32'h8C22_0004) begin failures++; $display("FAIL fetch_iload got=%0h exp=8c220004", iload); end
        cyc();
        iREN = 1'b0; ramready = 1'b0; #1;
        checks++; if (ramREN !== 1'b0) begin failures++; $display("FAIL fetch_idle_ren got=%0h exp=0", ramREN); end
        cyc();
    endtask

    task automatic test_store();
        dWEN = 1'b1; dREN = 1'b1; daddr = 32'h100; dstore = 32'hDEAD_BEEF;
        ramready = 1'b1; #1;
        checks++; if (dwait !== 1'b1) begin failures++; $display("FAIL store_dwait_T got=%0h exp=1", dwait); end
        checks++; if (ramWEN !== 1'b0) begin failures++; $display("FAIL store_wen_T got=%0h exp=0", ramWEN); end
        cyc(); #1;
        checks++; if (ramWEN !== 1'b1) begin failures++; $display("FAIL store_wen got=%0h exp=1", ramWEN); end
        checks++; if (ramREN !== 1'b0) begin failures++; $display("FAIL store_ren got=%0h exp=0", ramREN); end
        checks++; if (ramstore !== 32'hDEAD_BEEF) begin failures++; $display("FAIL store_data got=%0h exp=deadbeef", ramstore); end
        checks++; if (ramaddr !== 32'h100) begin failures++; $display("FAIL store_addr got=%0h exp=100", ramaddr); end
        checks++; if (dwait !== 1'b0) begin failures++; $display("FAIL store_dwait got=%0h exp=0", dwait); end
        cyc();
        dWEN = 1'b0; dREN = 1'b0; ramready = 1'b0; #1;
        checks++; if (ramWEN !== 1'b0) begin failures++; $display("FAIL store_idle_wen got=%0h exp=0", ramWEN); end
        cyc();
    endtask

    task automatic test_contention();
        iREN = 1'b1; iaddr = 32'h44; dREN = 1'b1; daddr = 32'h200;
        ramready = 1'b1; ramload = 32'h1111_1111;
        cyc(); #1;
        checks++; if (ramaddr !== 32'h200) begin failures++; $display("FAIL cont_daddr got=%0h exp=200", ramaddr); end
        checks++; if (dwait !== 1'b0) begin failures++; $display("FAIL cont_dwait got=%0h exp=0", dwait); end
        checks++; if (dload !== 32'h1111_1111) begin failures++; $display("FAIL cont_dload got=%0h exp=11111111", dload); end
        checks++; if (iwait !== 1'b1) begin failures++; $display("FAIL cont_iwait_T1 got=%0h exp=1", iwait); end
        checks++; if (iload !== 32'h0) begin failures++; $display("FAIL cont_iload_T1 got=%0h exp=0", iload); end
        cyc();
        dREN = 1'b0; #1;
        checks++; if (ramREN !== 1'b0) begin failures++; $display("FAIL cont_idle_ren got=%0h exp=0", ramREN); end
        cyc();
        ramload = 32'h2222_2222; #1;
        checks++; if (ramaddr !== 32'h44) begin failures++; $display("FAIL cont_iaddr got=%0h exp=44", ramaddr); end
        checks++; if (iwait !== 1'b0) begin failures++; $display("FAIL cont_iwait_T3 got=%0h exp=0", iwait); end
        checks++; if (iload !== 32'h2222_2222) begin failures++; $display("FAIL cont_iload got=%0h exp=22222222", iload); end
        cyc();
        iREN = 1'b0; ramready = 1'b0;
        cyc();
    endtask

    task automatic test_starvation();
        logic [31:0] exp_addr;
        logic        exp_iw;
        iREN = 1'b1; iaddr = 32'h48; dREN = 1'b1; daddr = 32'h300;
        ramready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            cyc(); #1;
            if (i % 2 == 1) begin
                exp_addr = (GUARD && i == 5) ? 32'h48 : 32'h300;
                exp_iw   = !(GUARD && i == 5);
                checks++; if (ramaddr !== exp_addr) begin failures++; $display("FAIL starve_addr_%0d got=%0h exp=%0h", i, ramaddr, exp_addr); end
                checks++; if (iwait !== exp_iw) begin failures++; $display("FAIL starve_iwait_%0d got=%0h exp=%0h", i, iwait, exp_iw); end
                checks++; if (dwait !== !exp_iw) begin failures++; $display("FAIL starve_dwait_%0d got=%0h exp=%0h", i, dwait, !exp_iw); end
            end else begin
                checks++; if (ramREN !== 1'b0) begin failures++; $display("FAIL starve_idle_%0d got=%0h exp=0", i, ramREN); end
            end
        end
        cyc();
        iREN = 1'b0; dREN = 1'b0; ramready = 1'b0; #1;
        checks++; if (ramREN !== 1'b0) begin failures++; $display("FAIL starve_end_ren got=%0h exp=0", ramREN); end
        cyc();
    endtask

    task automatic test_abort();
        iREN = 1'b1; iaddr = 32'h4C; dREN = 1'b1; daddr = 32'h400;
        ramready = 1'b0;
        cyc();
        dREN = 1'b0; #1;
        checks++; if (ramREN !== 1'b1) begin failures++; $display("FAIL abort_ren_T1 got=%0h exp=1", ramREN); end
        checks++; if (ramaddr !== 32'h400) begin failures++; $display("FAIL abort_addr got=%0h exp=400", ramaddr); end
        checks++; if (dwait !== 1'b0) begin failures++; $display("FAIL abort_dwait got=%0h exp=0", dwait); end
        cyc(); cyc(); #1;
        checks++; if (ramREN !== 1'b1) begin failures++; $display("FAIL abort_ren_T3 got=%0h exp=1", ramREN); end
        cyc();
        ramready = 1'b1; #1;
        checks++; if (ramREN !== 1'b1) begin failures++; $display("FAIL abort_ren_T4 got=%0h exp=1", ramREN); end
        checks++; if (iwait !== 1'b1) begin failures++; $display("FAIL abort_iwait_T4 got=%0h exp=1", iwait); end
        cyc();
        ramready = 1'b0; #1;
        checks++; if (ramREN !== 1'b0) begin failures++; $display("FAIL abort_idle_T5 got=%0h exp=0", ramREN); end
        cyc();
        ramready = 1'b1; #1;
        checks++; if (ramaddr !== 32'h4C) begin failures++; $display("FAIL abort_iaddr got=%0h exp=4c", ramaddr); end
        checks++; if (iwait !== 1'b0) begin failures++; $display("FAIL abort_iwait_T6 got=%0h exp=0", iwait); end
        cyc();
        iREN = 1'b0; ramready = 1'b0;
        cyc();
    endtask

    task automatic test_async_reset();
        dWEN = 1'b1; daddr = 32'h500; dstore = 32'hCAFE_F00D; ramready = 1'b0;
        cyc(); #1;
        checks++; if (ramWEN !== 1'b1) begin failures++; $display("FAIL areset_wen_pre got=%0h exp=1", ramWEN); end
        #1 RST = 1'b1; #1;
        checks++; if (ramWEN !== 1'b0) begin failures++; $display("FAIL areset_wen got=%0h exp=0", ramWEN); end
        checks++; if (ramREN !== 1'b0) begin failures++; $display("FAIL areset_ren got=%0h exp=0", ramREN); end
        checks++; if (ramaddr !== 32'h0) begin failures++; $display("FAIL areset_addr got=%0h exp=0", ramaddr); end
        checks++; if (ramstore !== 32'h0) begin failures++; $display("FAIL areset_store got=%0h exp=0", ramstore); end
        checks++; if (dwait !== 1'b1) begin failures++; $display("FAIL areset_dwait got=%0h exp=1", dwait); end
        #1 RST = 1'b0;
        cyc();
        ramready = 1'b1; #1;
        checks++; if (ramWEN !== 1'b1) begin failures++; $display("FAIL areset_regrant got=%0h exp=1", ramWEN); end
        checks++; if (ramaddr !== 32'h500) begin failures++; $display("FAIL areset_readdr got=%0h exp=500", ramaddr); end
        checks++; if (ramstore !== 32'hCAFE_F00D) begin failures++; $display("FAIL areset_restore got=%0h exp=cafef00d", ramstore); end
        checks++; if (dwait !== 1'b0) begin failures++; $display("FAIL areset_ack got=%0h exp=0", dwait); end
        cyc();
        dWEN = 1'b0; ramready = 1'b0;
        cyc();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store();
        test_contention();
        test_starvation();
        test_abort();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
